// File: rtl/pixel_bank_arbiter.sv
// rtl/pixel_bank_arbiter.sv - single-port pixel bank arbiter with clear sweep
// Arbitrates writer/reader access to the pixel bank and sequences full-bank clears.
module pixel_bank_arbiter #(
  parameter int NUM_CELLS = 784,
  parameter int ADDR_W    = 10
) (
  input  logic              Clock,
  input  logic              Clr_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic              w_d,
  output logic              w_gnt,
  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_gnt,
  output logic              r_valid,
  output logic              r_q,
  output logic              bank_we,
  output logic [ADDR_W-1:0] bank_addr,
  output logic              bank_d,
  input  logic              bank_q
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CELLS);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lp_q, lp_d;       // 1: reader was last served
  logic              r_oor_q, r_oor_d;
  logic              w_gnt_q, w_gnt_d;
  logic              r_gnt_q, r_gnt_d;
  logic              r_valid_q, r_valid_d;
  logic              r_q_q, r_q_d;
  logic              bank_we_q, bank_we_d;
  logic [ADDR_W-1:0] bank_addr_q, bank_addr_d;
  logic              bank_d_q, bank_d_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;

  logic arbitrate, w_elig, r_elig, pick_w;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lp_d        = lp_q;
    r_oor_d     = r_oor_q;
    w_gnt_d     = 1'b0;
    r_gnt_d     = 1'b0;
    bank_we_d   = 1'b0;
    bank_addr_d = bank_addr_q;
    bank_d_d    = 1'b0;
    clr_busy_d  = 1'b0;
    clr_done_d  = 1'b0;
    arbitrate   = 1'b0;
    // A read issued last cycle completes regardless of what starts now.
    r_valid_d   = r_gnt_q;
    r_q_d       = r_gnt_q & bank_q & ~r_oor_q;

    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d     = CLEAR;
          clr_busy_d  = 1'b1;
          bank_we_d   = 1'b1;
          bank_addr_d = '0;
          cnt_d       = CNT_W'(1);
        end else begin
          arbitrate = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_CNT) begin
          state_d    = IDLE;
          cnt_d      = '0;
          clr_done_d = 1'b1;
          arbitrate  = 1'b1;
        end else begin
          clr_busy_d  = 1'b1;
          bank_we_d   = 1'b1;
          bank_addr_d = cnt_q[ADDR_W-1:0];
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A requester granted this cycle sits out the next arbitration.
    w_elig = arbitrate & w_req & ~w_gnt_q;
    r_elig = arbitrate & r_req & ~r_gnt_q;
    pick_w = w_elig & (~r_elig | lp_q);

    if (pick_w) begin
      w_gnt_d     = 1'b1;
      bank_addr_d = w_addr;
      bank_d_d    = w_d;
      bank_we_d   = ({1'b0, w_addr} < LAST_CNT);
    end else if (r_elig) begin
      r_gnt_d     = 1'b1;
      bank_addr_d = r_addr;
      r_oor_d     = ({1'b0, r_addr} >= LAST_CNT);
    end

    if (w_elig && r_elig) begin
      lp_d = ~pick_w;
    end
  end

  always_ff @(posedge Clock or negedge Clr_n) begin
    if (!Clr_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lp_q        <= 1'b1;
      r_oor_q     <= 1'b0;
      w_gnt_q     <= 1'b0;
      r_gnt_q     <= 1'b0;
      r_valid_q   <= 1'b0;
      r_q_q       <= 1'b0;
      bank_we_q   <= 1'b0;
      bank_addr_q <= '0;
      bank_d_q    <= 1'b0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lp_q        <= lp_d;
      r_oor_q     <= r_oor_d;
      w_gnt_q     <= w_gnt_d;
      r_gnt_q     <= r_gnt_d;
      r_valid_q   <= r_valid_d;
      r_q_q       <= r_q_d;
      bank_we_q   <= bank_we_d;
      bank_addr_q <= bank_addr_d;
      bank_d_q    <= bank_d_d;
      clr_busy_q  <= clr_busy_d;
      clr_done_q  <= clr_done_d;
    end
  end

  assign w_gnt     = w_gnt_q;
  assign r_gnt     = r_gnt_q;
  assign r_valid   = r_valid_q;
  assign r_q       = r_q_q;
  assign bank_we   = bank_we_q;
  assign bank_addr = bank_addr_q;
  assign bank_d    = bank_d_q;
  assign clr_busy  = clr_busy_q;
  assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_pixel_bank_arbiter.sv
// tb/tb_pixel_bank_arbiter.sv - directed vector bench for pixel_bank_arbiter
module tb_pixel_bank_arbiter;

  localparam int NUM_CELLS = 784;
  localparam int ADDR_W    = 10;

  logic              Clock = 1'b0;
  logic              Clr_n;
  logic              clr_req, clr_busy, clr_done;
  logic              w_req, w_d, w_gnt;
  logic [ADDR_W-1:0] w_addr, r_addr, bank_addr;
  logic              r_req, r_gnt, r_valid, r_q;
  logic              bank_we, bank_d, bank_q;

  pixel_bank_arbiter #(.NUM_CELLS(NUM_CELLS), .ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .Clr_n(Clr_n),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .w_req(w_req), .w_addr(w_addr), .w_d(w_d), .w_gnt(w_gnt),
    .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt),
    .r_valid(r_valid), .r_q(r_q),
    .bank_we(bank_we), .bank_addr(bank_addr), .bank_d(bank_d), .bank_q(bank_q)
  );

  always #5 Clock = ~Clock;

  // Bank model; out-of-range reads return 1 so the arbiter must mask them.
  logic mem [0:NUM_CELLS-1];
  assign bank_q = (int'(bank_addr) < NUM_CELLS) ? mem[bank_addr] : 1'b1;
  always @(posedge Clock)
    if (bank_we && int'(bank_addr) < NUM_CELLS) mem[bank_addr] <= bank_d;

  typedef struct {
    logic              wr; logic [ADDR_W-1:0] wa; logic wd;
    logic              rr; logic [ADDR_W-1:0] ra; logic clr;
    logic              e_wg, e_rg, e_rv, e_rq, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic              e_d, e_busy, e_done;
  } vec_t;

  vec_t vecs [16];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic vec_t mk(input logic wr, input int wa, input logic wd,
                              input logic rr, input int ra,
                              input logic wg, input logic rg, input logic rv,
                              input logic rq, input logic we, input int addr,
                              input logic d);
    vec_t v;
    v.wr = wr; v.wa = ADDR_W'(wa); v.wd = wd; v.rr = rr; v.ra = ADDR_W'(ra);
    v.clr = 1'b0; v.e_wg = wg; v.e_rg = rg; v.e_rv = rv; v.e_rq = rq;
    v.e_we = we; v.e_addr = ADDR_W'(addr); v.e_d = d;
    v.e_busy = 1'b0; v.e_done = 1'b0;
    return v;
  endfunction

  initial begin
    int errs;
    bit found;
    for (int i = 0; i < NUM_CELLS; i++) mem[i] = 1'b0;

    //            wr wa  wd rr ra    wg rg rv rq we addr d
    vecs[0]  = mk(1, 5,   1, 0, 0,    1, 0, 0, 0, 1, 5,   1);
    vecs[1]  = mk(0, 5,   0, 1, 5,    0, 1, 0, 0, 0, 5,   0);
    vecs[2]  = mk(0, 0,   0, 0, 0,    0, 0, 1, 1, 0, 5,   0);
    vecs[3]  = mk(1, 800, 1, 0, 0,    1, 0, 0, 0, 0, 800, 1);
    vecs[4]  = mk(0, 0,   0, 1, 1000, 0, 1, 0, 0, 0, 1000,0);
    vecs[5]  = mk(0, 0,   0, 0, 0,    0, 0, 1, 0, 0, 1000,0);
    vecs[6]  = mk(1, 7,   1, 1, 5,    1, 0, 0, 0, 1, 7,   1);
    vecs[7]  = mk(1, 7,   1, 1, 5,    0, 1, 0, 0, 0, 5,   0);
    vecs[8]  = mk(1, 7,   1, 1, 5,    1, 0, 1, 1, 1, 7,   1);
    vecs[9]  = mk(1, 7,   1, 1, 5,    0, 1, 0, 0, 0, 5,   0);
    vecs[10] = mk(1, 7,   1, 1, 5,    1, 0, 1, 1, 1, 7,   1);
    vecs[11] = mk(1, 7,   1, 1, 5,    0, 1, 0, 0, 0, 5,   0);
    vecs[12] = mk(1, 7,   1, 1, 5,    1, 0, 1, 1, 1, 7,   1);
    vecs[13] = mk(1, 7,   1, 1, 5,    0, 1, 0, 0, 0, 5,   0);
    vecs[14] = mk(0, 0,   0, 0, 0,    0, 0, 1, 1, 0, 5,   0);
    vecs[15] = mk(0, 0,   0, 0, 0,    0, 0, 0, 0, 0, 5,   0);

    Clr_n = 1'b0; clr_req = 0; w_req = 0; w_addr = '0; w_d = 0;
    r_req = 0; r_addr = '0;
    repeat (2) step();
    check("reset_outputs",
          int'({w_gnt, r_gnt, r_valid, r_q, bank_we, bank_d, clr_busy, clr_done, bank_addr}), 0);
    Clr_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      w_req = vecs[i].wr; w_addr = vecs[i].wa; w_d = vecs[i].wd;
      r_req = vecs[i].rr; r_addr = vecs[i].ra; clr_req = vecs[i].clr;
      step();
      check($sformatf("v%0d_w_gnt", i),     int'(w_gnt),     int'(vecs[i].e_wg));
      check($sformatf("v%0d_r_gnt", i),     int'(r_gnt),     int'(vecs[i].e_rg));
      check($sformatf("v%0d_r_valid", i),   int'(r_valid),   int'(vecs[i].e_rv));
      check($sformatf("v%0d_r_q", i),       int'(r_q),       int'(vecs[i].e_rq));
      check($sformatf("v%0d_bank_we", i),   int'(bank_we),   int'(vecs[i].e_we));
      check($sformatf("v%0d_bank_addr", i), int'(bank_addr), int'(vecs[i].e_addr));
      check($sformatf("v%0d_bank_d", i),    int'(bank_d),    int'(vecs[i].e_d));
      check($sformatf("v%0d_clr_busy", i),  int'(clr_busy),  int'(vecs[i].e_busy));
      check($sformatf("v%0d_clr_done", i),  int'(clr_done),  int'(vecs[i].e_done));
    end

    // Clear sweep with a writer held pending throughout.
    w_req = 1; w_addr = 10'd9; w_d = 1; clr_req = 1;
    step();
    clr_req = 0;
    errs = 0;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (k > 0) begin
        clr_req = (k == 100);
        step();
      end
      if (!(clr_busy && bank_we && !bank_d && int'(bank_addr) == k && !w_gnt && !clr_done)) errs++;
    end
    clr_req = 0;
    check("clear_sweep_cycles_bad", errs, 0);
    step();
    check("clr_done_pulse", int'(clr_done), 1);
    check("clr_busy_after", int'(clr_busy), 0);
    check("w_gnt_in_done_cycle", int'(w_gnt), 1);
    check("done_cycle_addr", int'(bank_addr), 9);
    check("done_cycle_we", int'(bank_we), 1);
    w_req = 0;
    step();
    check("clr_done_one_cycle", int'(clr_done), 0);
    r_req = 1; r_addr = 10'd5;
    step();
    check("post_clear_r_gnt", int'(r_gnt), 1);
    r_req = 0;
    step();
    check("post_clear_r_valid", int'(r_valid), 1);
    check("post_clear_r_q", int'(r_q), 0);

    // Reset in the middle of a sweep.
    clr_req = 1;
    step();
    clr_req = 0;
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (int'(bank_addr) == 300 && clr_busy) found = 1;
      else step();
    end
    check("reached_addr_300", int'(found), 1);
    #2 Clr_n = 1'b0;
    #1;
    check("async_reset_outputs",
          int'({w_gnt, r_gnt, r_valid, r_q, bank_we, bank_d, clr_busy, clr_done, bank_addr}), 0);
    step();
    Clr_n = 1'b1;
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (clr_done || clr_busy || bank_we) errs++;
    end
    check("no_done_after_abort", errs, 0);
    w_req = 1; w_addr = 10'd3; w_d = 1;
    step();
    w_req = 0;
    check("after_reset_w_gnt", int'(w_gnt), 1);
    check("after_reset_addr", int'(bank_addr), 3);
    check("after_reset_we", int'(bank_we), 1);
    check("after_reset_d", int'(bank_d), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
